time_keeper: RTL and testbench

//  24-hour HH:MM:SS time-of-day counter with button-driven set mode. Sits directly

---
 rtl/clock_pkg.sv | 30 +++
 rtl/time_keeper_bcd_field.sv | 39 +++
 rtl/time_keeper.sv | 99 +++++++++
 tb/tb_time_keeper.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the time-of-day counter and its display packing.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  typedef struct packed {
    logic       en;
    logic [3:0] val;
    logic       dp;
  } digit_t;

  // Unlit digit with the active-low decimal point held off
  localparam digit_t BLANK_DIGIT = '{en: 1'b0, val: 4'd0, dp: 1'b1};

  localparam logic [3:0] HR_MAX_T = 4'd2;
  localparam logic [3:0] HR_MAX_U = 4'd3;

  function automatic digit_t make_digit(input logic en, input logic [3:0] val, input logic dp);
    digit_t d;
    d.en  = en;
    d.val = val;
    d.dp  = dp;
    return d;
  endfunction

endpackage

// File: rtl/time_keeper_bcd_field.sv
// Two-digit BCD counter that rolls over to 00 after LIMIT; wrap flags that rollover.
module bcd_field #(
  parameter int LIMIT = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       wrap
);

  localparam logic [3:0] LIM_T = 4'(LIMIT / 10);
  localparam logic [3:0] LIM_U = 4'(LIMIT % 10);

  logic at_limit;

  assign at_limit = (tens == LIM_T) && (units == LIM_U);
  assign wrap     = inc && at_limit;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (inc) begin
      if (at_limit) begin
        tens  <= 4'd0;
        units <= 4'd0;
      end else if (units == 4'd9) begin
        tens  <= tens + 4'd1;
        units <= 4'd0;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/time_keeper.sv
// 24-hour HH:MM:SS counter with button set mode, feeding sseg_driver digit words.
// Define TIME_KEEPER_BLINK_EN to blink the field being edited in the set states.
module time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_btn,
  input  logic       inc_btn,
  output logic [5:0] l0,
  output logic [5:0] l1,
  output logic [5:0] l2,
  output logic [5:0] l3,
  output logic [5:0] l4,
  output logic [5:0] l5,
  output logic [5:0] l6,
  output logic [5:0] l7,
  output logic       sec_tick,
  output logic [1:0] mode
);

  localparam int             PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc;
  state_t        state;
  logic          tick, leave_set;
  logic          sec_inc, min_inc, hr_inc;
  logic          sec_wrap, min_wrap, hr_wrap_unused;
  logic [3:0]    sec_t, sec_u, min_t, min_u, hr_t, hr_u;
  logic          hr_en, min_en;

  assign tick      = (presc == PRESC_MAX);
  assign sec_tick  = tick;
  assign leave_set = (state == SET_MIN) && set_btn;
  assign mode      = state;

  // Leaving set mode restarts the second so the new time starts on a clean boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      state <= RUN;
    end else begin
      presc <= (tick || leave_set) ? '0 : presc + 1'b1;
      if (set_btn) begin
        case (state)
          RUN:     state <= SET_HR;
          SET_HR:  state <= SET_MIN;
          default: state <= RUN;
        endcase
      end
    end
  end

  // A set_btn in the same cycle wins over inc_btn; set-mode increments never carry
  assign sec_inc = (state == RUN) && tick;
  assign min_inc = (state == RUN) ? sec_wrap
                                  : ((state == SET_MIN) && inc_btn && !set_btn);
  assign hr_inc  = (state == RUN) ? min_wrap
                                  : ((state == SET_HR) && inc_btn && !set_btn);

  bcd_field #(.LIMIT(59)) u_sec (
    .clk(clk), .reset(reset), .clr(leave_set), .inc(sec_inc),
    .tens(sec_t), .units(sec_u), .wrap(sec_wrap)
  );

  bcd_field #(.LIMIT(59)) u_min (
    .clk(clk), .reset(reset), .clr(1'b0), .inc(min_inc),
    .tens(min_t), .units(min_u), .wrap(min_wrap)
  );

  bcd_field #(.LIMIT(int'(HR_MAX_T) * 10 + int'(HR_MAX_U))) u_hr (
    .clk(clk), .reset(reset), .clr(1'b0), .inc(hr_inc),
    .tens(hr_t), .units(hr_u), .wrap(hr_wrap_unused)
  );

`ifdef TIME_KEEPER_BLINK_EN
  logic phase;
  assign phase  = (presc >= PW'(CLK_HZ / 2));
  assign hr_en  = !((state == SET_HR) && phase);
  assign min_en = !((state == SET_MIN) && phase);
`else
  assign hr_en  = 1'b1;
  assign min_en = 1'b1;
`endif

  // Decimal points on hr_u and min_u render as HH.MM.SS
  assign l0 = make_digit(1'b1,   sec_u, 1'b1);
  assign l1 = make_digit(1'b1,   sec_t, 1'b1);
  assign l2 = make_digit(min_en, min_u, 1'b0);
  assign l3 = make_digit(min_en, min_t, 1'b1);
  assign l4 = make_digit(hr_en,  hr_u,  1'b0);
  assign l5 = make_digit(hr_en,  hr_t,  1'b1);
  assign l6 = BLANK_DIGIT;
  assign l7 = BLANK_DIGIT;

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper at CLK_HZ=4: stimulus queues expectations, a monitor checks them.
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       reset, set_btn, inc_btn;
  logic [5:0] l0, l1, l2, l3, l4, l5, l6, l7;
  logic       sec_tick;
  logic [1:0] mode;

  time_keeper #(.CLK_HZ(4)) dut (
    .clk(clk), .reset(reset), .set_btn(set_btn), .inc_btn(inc_btn),
    .l0(l0), .l1(l1), .l2(l2), .l3(l3), .l4(l4), .l5(l5), .l6(l6), .l7(l7),
    .sec_tick(sec_tick), .mode(mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [47:0] l;
    logic [47:0] msk;
    logic [1:0]  mode;
    logic        tick;
    logic        tick_care;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [47:0] FULL = '1;
  // Blinking enables (l5,l4,l3,l2 en bits) are don't-care during set-mode checks
  localparam logic [47:0] NOBLINK = ~((48'd1 << 35) | (48'd1 << 29) | (48'd1 << 23) | (48'd1 << 17));

  function automatic logic [47:0] disp(input int h, input int m, input int s,
                                        input logic hr_en, input logic min_en);
    return {6'b000001, 6'b000001,
            hr_en,  4'(h / 10), 1'b1,
            hr_en,  4'(h % 10), 1'b0,
            min_en, 4'(m / 10), 1'b1,
            min_en, 4'(m % 10), 1'b0,
            1'b1,   4'(s / 10), 1'b1,
            1'b1,   4'(s % 10), 1'b1};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_t(input string name, input int h, input int m, input int s,
                          input logic [1:0] md, input logic tk, input logic tk_care,
                          input logic [47:0] msk, input logic hr_en, input logic min_en);
    exp_t e;
    e.name      = name;
    e.l         = disp(h, m, s, hr_en, min_en);
    e.msk       = msk;
    e.mode      = md;
    e.tick      = tk;
    e.tick_care = tk_care;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic press_set();
    set_btn = 1'b1;
    step(1);
    set_btn = 1'b0;
  endtask

  task automatic press_inc(input int n);
    inc_btn = 1'b1;
    step(n);
    inc_btn = 1'b0;
  endtask

  // Monitor: the display is always valid, so any pending expectation is checked at the next negedge
  always @(negedge clk) begin
    exp_t        e;
    logic [47:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {l7, l6, l5, l4, l3, l2, l1, l0};
      n_tests++;
      if (((act ^ e.l) & e.msk) != 48'd0) begin
        n_fail++;
        $display("FAIL %s digits: got %012h want %012h (mask %012h)", e.name, act, e.l, e.msk);
      end
      n_tests++;
      if (mode !== e.mode) begin
        n_fail++;
        $display("FAIL %s mode: got %0d want %0d", e.name, mode, e.mode);
      end
      if (e.tick_care) begin
        n_tests++;
        if (sec_tick !== e.tick) begin
          n_fail++;
          $display("FAIL %s sec_tick: got %0b want %0b", e.name, sec_tick, e.tick);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    set_btn = 1'b0;
    inc_btn = 1'b0;
    step(2);
    expect_t("reset", 0, 0, 0, 2'd0, 1'b0, 1'b1, FULL, 1'b1, 1'b1);
    reset = 1'b0;

    // Seconds roll into minutes
    step(236);
    expect_t("at_00_00_59", 0, 0, 59, 2'd0, 1'b0, 1'b1, FULL, 1'b1, 1'b1);
    step(3);
    expect_t("tick_59", 0, 0, 59, 2'd0, 1'b1, 1'b1, FULL, 1'b1, 1'b1);
    step(1);
    expect_t("min_carry", 0, 1, 0, 2'd0, 1'b0, 1'b1, FULL, 1'b1, 1'b1);

    // Build 23:59:59 through set mode, then roll the day over
    press_set();
    press_inc(23);
    expect_t("set_hr_23", 23, 1, 0, 2'd1, 1'b0, 1'b0, NOBLINK, 1'b1, 1'b1);
    press_set();
    press_inc(58);
    expect_t("set_min_59", 23, 59, 0, 2'd2, 1'b0, 1'b0, NOBLINK, 1'b1, 1'b1);
    press_set();
    expect_t("exit_set_1", 23, 59, 0, 2'd0, 1'b0, 1'b1, FULL, 1'b1, 1'b1);
    step(236);
    expect_t("at_23_59_59", 23, 59, 59, 2'd0, 1'b0, 1'b1, FULL, 1'b1, 1'b1);
    step(4);
    expect_t("day_wrap", 0, 0, 0, 2'd0, 1'b0, 1'b1, FULL, 1'b1, 1'b1);

    // Set mode wraps fields without carry, freezes time, clears seconds and prescaler on exit
    step(10);
    expect_t("run_00_00_02", 0, 0, 2, 2'd0, 1'b0, 1'b1, FULL, 1'b1, 1'b1);
    press_set();
    press_inc(25);
    expect_t("hr_wrap_25", 1, 0, 2, 2'd1, 1'b0, 1'b0, NOBLINK, 1'b1, 1'b1);
    press_set();
    press_inc(61);
    expect_t("min_wrap_61", 1, 1, 2, 2'd2, 1'b0, 1'b0, NOBLINK, 1'b1, 1'b1);
    press_set();
    expect_t("exit_clears_sec", 1, 1, 0, 2'd0, 1'b0, 1'b1, FULL, 1'b1, 1'b1);
    step(3);
    expect_t("presc_cleared", 1, 1, 0, 2'd0, 1'b1, 1'b1, FULL, 1'b1, 1'b1);
    step(1);
    expect_t("run_resumes", 1, 1, 1, 2'd0, 1'b0, 1'b1, FULL, 1'b1, 1'b1);

    // Simultaneous buttons, reset mid-set, inc ignored in RUN
    press_set();
    set_btn = 1'b1;
    inc_btn = 1'b1;
    step(1);
    set_btn = 1'b0;
    inc_btn = 1'b0;
    expect_t("set_and_inc", 1, 1, 1, 2'd2, 1'b0, 1'b0, NOBLINK, 1'b1, 1'b1);
    press_inc(3);
    expect_t("min_inc_3", 1, 4, 1, 2'd2, 1'b0, 1'b0, NOBLINK, 1'b1, 1'b1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    expect_t("reset_in_set", 0, 0, 0, 2'd0, 1'b0, 1'b1, FULL, 1'b1, 1'b1);
    press_inc(2);
    expect_t("inc_in_run", 0, 0, 0, 2'd0, 1'b0, 1'b1, FULL, 1'b1, 1'b1);

    // Enter SET_MIN with the prescaler at 0 and watch the minute enables
    press_set();
    press_set();
    for (int i = 0; i < 8; i++) begin
`ifdef TIME_KEEPER_BLINK_EN
      expect_t($sformatf("blink_%0d", i), 0, 0, 0, 2'd2, (i % 4) == 3, 1'b1, FULL,
               1'b1, (i % 4) < 2);
`else
      expect_t($sformatf("blink_%0d", i), 0, 0, 0, 2'd2, (i % 4) == 3, 1'b1, FULL,
               1'b1, 1'b1);
`endif
      step(1);
    end

    step(2);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
